// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_addr_gen
//  Brief    : Two-level strided address generator (row/col loop nest) that
//             streams linear feature-map addresses over a valid/ready port.
//             addr = base + row*pitch + col, with a shared row/col stride.
//  Options  : CONV_WINDOW_ADDR_GEN_ASSERT_EN - compiles runtime protocol
//             assertions, each gated by assert_on_i.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_addr_gen #(
  parameter int ADDR_BITS = 16,
  parameter int DIM_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_addr_i,
  input  logic [ADDR_BITS-1:0] pitch_i,
  input  logic [DIM_BITS-1:0]  cols_i,
  input  logic [DIM_BITS-1:0]  rows_i,
  input  logic [DIM_BITS-1:0]  stride_i,
  input  logic                 assert_on_i,
  output logic                 busy_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [DIM_BITS-1:0]  row_o,
  output logic [DIM_BITS-1:0]  col_o,
  output logic                 last_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched configuration; live inputs are ignored once a scan starts.
  logic [ADDR_BITS-1:0] r_base;
  logic [ADDR_BITS-1:0] r_pitch;
  logic [DIM_BITS-1:0]  r_cols;
  logic [DIM_BITS-1:0]  r_rows;
  logic [DIM_BITS-1:0]  r_stride;

  // Loop-nest state.
  logic [ADDR_BITS-1:0] r_row_step;
  logic [ADDR_BITS-1:0] r_row_base;
  logic [DIM_BITS-1:0]  r_row;
  logic [DIM_BITS-1:0]  r_col;

  logic                 w_fire;
  logic                 w_empty;
  logic [DIM_BITS:0]    w_col_sum;
  logic [DIM_BITS:0]    w_row_sum;
  logic                 w_col_wrap;
  logic                 w_row_wrap;

  // One extra bit on the sums so col+stride / row+stride can never overflow
  // before the compare against the exclusive end.
  assign w_col_sum  = {1'b0, r_col} + {1'b0, r_stride};
  assign w_row_sum  = {1'b0, r_row} + {1'b0, r_stride};
  assign w_col_wrap = (w_col_sum >= {1'b0, r_cols});
  assign w_row_wrap = (w_row_sum >= {1'b0, r_rows});
  assign w_fire     = (r_state == S_RUN) && ready_i;
  assign w_empty    = (cols_i == '0) || (rows_i == '0);

  assign busy_o  = (r_state == S_LOAD) || (r_state == S_RUN);
  assign valid_o = (r_state == S_RUN);
  assign done_o  = (r_state == S_DONE);
  assign last_o  = valid_o && w_col_wrap && w_row_wrap;
  assign addr_o  = r_row_base + ADDR_BITS'(r_col);
  assign row_o   = r_row;
  assign col_o   = r_col;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: empty scans skip straight to DONE with no beats.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = w_empty ? S_DONE : S_LOAD;
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN:  if (w_fire && w_col_wrap && w_row_wrap) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch and loop-nest counters; counters only move on a handshake,
  // which is what holds the outputs stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base     <= '0;
      r_pitch    <= '0;
      r_cols     <= '0;
      r_rows     <= '0;
      r_stride   <= '0;
      r_row_step <= '0;
      r_row_base <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base   <= base_addr_i;
            r_pitch  <= pitch_i;
            r_cols   <= cols_i;
            r_rows   <= rows_i;
            r_stride <= (stride_i == '0) ? DIM_BITS'(1) : stride_i;
          end
        end
        S_LOAD: begin
          r_row_step <= ADDR_BITS'(r_pitch * ADDR_BITS'(r_stride));
          r_row_base <= r_base;
          r_row      <= '0;
          r_col      <= '0;
        end
        S_RUN: begin
          if (ready_i) begin
            if (!w_col_wrap) begin
              r_col <= w_col_sum[DIM_BITS-1:0];
            end else if (!w_row_wrap) begin
              r_col      <= '0;
              r_row      <= w_row_sum[DIM_BITS-1:0];
              r_row_base <= r_row_base + r_row_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_WINDOW_ADDR_GEN_ASSERT_EN
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
    (valid_o && !ready_i) |=> ($stable(addr_o) && $stable(row_o) && $stable(col_o) && $stable(last_o)))
    else $error("stream outputs changed while stalled");

  a_valid_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
    valid_o |-> (r_state == S_RUN))
    else $error("valid_o outside RUN");

  a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
    done_o |=> !done_o)
    else $error("done_o wider than one cycle");

  a_index_range: assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
    valid_o |-> ((row_o < r_rows) && (col_o < r_cols)))
    else $error("row/col index out of range");

  a_start_busy: assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
    !(start_i && busy_o))
    else $warning("start_i while busy is ignored");
`else
  logic w_unused_assert_on;
  assign w_unused_assert_on = assert_on_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_addr_gen
//  Brief    : Directed self-checking bench for conv_window_addr_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_addr_gen;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] base_addr_i;
  logic [15:0] pitch_i;
  logic [7:0]  cols_i;
  logic [7:0]  rows_i;
  logic [7:0]  stride_i;
  logic        assert_on_i;
  logic        busy_o;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] addr_o;
  logic [7:0]  row_o;
  logic [7:0]  col_o;
  logic        last_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q_addr[$];
  int          q_row[$];
  int          q_col[$];
  int          q_last[$];
  logic [15:0] q_stall[$];
  int          first_valid_cyc;
  int          last_fire_cyc;
  int          done_cyc;

  logic [15:0] ea[$];
  int          er[$];
  int          ec[$];

  always #5 clk = ~clk;

  conv_window_addr_gen dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .pitch_i     (pitch_i),
    .cols_i      (cols_i),
    .rows_i      (rows_i),
    .stride_i    (stride_i),
    .assert_on_i (assert_on_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .addr_o      (addr_o),
    .row_o       (row_o),
    .col_o       (col_o),
    .last_o      (last_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge; returns one step after the edge
  // that sampled start_i, then scrambles the live config.
  task automatic start_scan(input logic [15:0] b, input logic [15:0] p,
                            input logic [7:0] c, input logic [7:0] r, input logic [7:0] s);
    base_addr_i = b; pitch_i = p; cols_i = c; rows_i = r; stride_i = s;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    base_addr_i = 16'hDEAD; pitch_i = 16'd7; cols_i = 8'd1; rows_i = 8'd1; stride_i = 8'd3;
  endtask

  // Drains beats until done_o; optional stall and stray start pulse.
  task automatic collect(input int stall_beat, input int stall_len, input int start_beat);
    int  stalls = 0;
    int  cyc = 0;
    bit  fin = 1'b0;
    q_addr.delete(); q_row.delete(); q_col.delete(); q_last.delete(); q_stall.delete();
    first_valid_cyc = -1; last_fire_cyc = -1; done_cyc = -1;
    while (!fin && cyc < 200) begin
      ready_i = !(valid_o && q_addr.size() == stall_beat && stalls < stall_len);
      if (!ready_i) stalls++;
      start_i = valid_o && (q_addr.size() == start_beat);
      #1;
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o && ready_i) begin
        q_addr.push_back(addr_o); q_row.push_back(int'(row_o));
        q_col.push_back(int'(col_o)); q_last.push_back(int'(last_o));
        last_fire_cyc = cyc;
      end
      if (valid_o && !ready_i) q_stall.push_back(addr_o);
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
      if (done_o) begin
        fin = 1'b1;
        done_cyc = cyc;
      end
    end
    ready_i = 1'b1;
    check("done_seen", 32'(fin), 32'd1);
    check("done_after_last", done_cyc, last_fire_cyc + 1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("idle_after_done", 32'(busy_o), 32'd0);
  endtask

  task automatic check_beats(input string tag);
    int n;
    check({tag, "_count"}, q_addr.size(), ea.size());
    n = (q_addr.size() < ea.size()) ? q_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(ea[i]));
      check($sformatf("%s_row%0d", tag, i), q_row[i], er[i]);
      check($sformatf("%s_col%0d", tag, i), q_col[i], ec[i]);
      check($sformatf("%s_last%0d", tag, i), q_last[i], (i == ea.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic set_basic_exp();
    ea = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h10A, 16'h10B,
           16'h10C, 16'h10D, 16'h114, 16'h115, 16'h116, 16'h117};
    er = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    ec = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o),  32'd0);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_last"},  32'(last_o),  32'd0);
    check({tag, "_done"},  32'(done_o),  32'd0);
    check({tag, "_addr"},  32'(addr_o),  32'd0);
    check({tag, "_row"},   32'(row_o),   32'd0);
    check({tag, "_col"},   32'(col_o),   32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; ready_i = 1'b1; assert_on_i = 1'b1;
    base_addr_i = '0; pitch_i = '0; cols_i = '0; rows_i = '0; stride_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Basic scan with latency checks.
    start_scan(16'h100, 16'd10, 8'd4, 8'd3, 8'd1);
    check("load_valid", 32'(valid_o), 32'd0);
    check("load_busy", 32'(busy_o), 32'd1);
    collect(-1, 0, -1);
    check("basic_first_valid", first_valid_cyc, 1);
    set_basic_exp();
    check_beats("basic");

    // Strided scan.
    start_scan(16'h0, 16'd5, 8'd5, 8'd5, 8'd2);
    collect(-1, 0, -1);
    ea = '{16'd0, 16'd2, 16'd4, 16'd10, 16'd12, 16'd14, 16'd20, 16'd22, 16'd24};
    er = '{0, 0, 0, 2, 2, 2, 4, 4, 4};
    ec = '{0, 2, 4, 0, 2, 4, 0, 2, 4};
    check_beats("stride");

    // Backpressure on the fifth beat.
    start_scan(16'h100, 16'd10, 8'd4, 8'd3, 8'd1);
    collect(4, 3, -1);
    set_basic_exp();
    check_beats("bp");
    check("bp_stall_cycles", q_stall.size(), 3);
    for (int i = 0; i < q_stall.size(); i++)
      check($sformatf("bp_hold%0d", i), 32'(q_stall[i]), 32'h10A);

    // Empty scan: rows = 0.
    start_scan(16'h40, 16'd3, 8'd4, 8'd0, 8'd1);
    check("empty_done", 32'(done_o), 32'd1);
    check("empty_valid", 32'(valid_o), 32'd0);
    check("empty_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    check("empty_done_drop", 32'(done_o), 32'd0);
    check("empty_valid2", 32'(valid_o), 32'd0);

    // Stride 0 behaves as 1.
    start_scan(16'h20, 16'd9, 8'd3, 8'd1, 8'd0);
    collect(-1, 0, -1);
    ea = '{16'h20, 16'h21, 16'h22};
    er = '{0, 0, 0};
    ec = '{0, 1, 2};
    check_beats("s0");

    // Reset in the middle of row 1.
    start_scan(16'h100, 16'd10, 8'd4, 8'd3, 8'd1);
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_addr", 32'(addr_o), 32'h10C);
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_nodone%0d", i), 32'(done_o), 32'd0);
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(busy_o), 32'd0);

    // Full scan after reset, with a stray start pulse during RUN.
    start_scan(16'h100, 16'd10, 8'd4, 8'd3, 8'd1);
    collect(-1, 0, 3);
    set_basic_exp();
    check_beats("rerun");
    repeat (3) @(posedge clk);
    #1;
    check("no_restart", 32'(busy_o), 32'd0);

    // Address wrap past 0xFFFF.
    start_scan(16'hFFFE, 16'd1, 8'd4, 8'd1, 8'd1);
    collect(-1, 0, -1);
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    er = '{0, 0, 0, 0};
    ec = '{0, 1, 2, 3};
    check_beats("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
